div_iter: RTL and testbench

- Multi-cycle 32-bit integer divider; responder side of the EX-stage divide handshake (start_i / ready_o) used for DIV and DIVU.
- EX holds start_i and the operands while ready_o is low, stalling the pipeline.
- The divider returns {remainder, quotient} for the HI/LO write and raises ready_o for one handshake window.
- Bit-serial restoring algorithm: MSB-first, one quotient bit per cycle.

---
 rtl/div_iter_if.sv | 23 ++
 rtl/div_iter.sv | 178 +++++++++++++++++
 tb/tb_div_iter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/div_iter_if.sv
// EX-stage divide handshake: EX (master) holds start_i and operands until ready_o,
// the divider (slave) returns {remainder, quotient}.
interface div_iter_if #(
  parameter int DATA_WD = 32
);
  logic                   signed_div_i;
  logic [DATA_WD-1:0]     opdata1_i;
  logic [DATA_WD-1:0]     opdata2_i;
  logic                   start_i;
  logic                   annul_i;
  logic [2*DATA_WD-1:0]   result_o;
  logic                   ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_iter.sv
// Bit-serial restoring divider for DIV/DIVU: one quotient bit per cycle, MSB first,
// fixed 33-cycle stall, registered {remainder, quotient} held while start_i stays high.
module div_iter #(
  parameter int DATA_WD = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_iter_if.slave  bus
);

  localparam int W  = DATA_WD;
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [CW-1:0]   cnt_r, cnt_nxt_s;
  logic [W:0]      rem_r, rem_nxt_s;
  logic [W-1:0]    quo_r, quo_nxt_s;
  logic [W-1:0]    div_r, div_nxt_s;
  logic            sdiv_r, sdiv_nxt_s;
  logic            s1_r, s1_nxt_s;
  logic            s2_r, s2_nxt_s;
  logic [2*W-1:0]  result_r, result_nxt_s;
  logic            ready_r, ready_nxt_s;

  logic [W:0]      trial_s;
  logic [W-1:0]    abs1_s, abs2_s, quo_fix_s, rem_fix_s;

  assign bus.result_o = result_r;
  assign bus.ready_o  = ready_r;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CW{1'b0}};
      rem_r    <= {(W+1){1'b0}};
      quo_r    <= {W{1'b0}};
      div_r    <= {W{1'b0}};
      sdiv_r   <= 1'b0;
      s1_r     <= 1'b0;
      s2_r     <= 1'b0;
      result_r <= {(2*W){1'b0}};
      ready_r  <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      rem_r    <= rem_nxt_s;
      quo_r    <= quo_nxt_s;
      div_r    <= div_nxt_s;
      sdiv_r   <= sdiv_nxt_s;
      s1_r     <= s1_nxt_s;
      s2_r     <= s2_nxt_s;
      result_r <= result_nxt_s;
      ready_r  <= ready_nxt_s;
    end
  end

  // Next-state logic; annul wins over completion in BYZERO and ON
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          state_nxt_s = (bus.opdata2_i == {W{1'b0}}) ? ST_BYZERO : ST_ON;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BYZERO: begin
        if (bus.annul_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_END;
        end
      end
      ST_ON: begin
        if (bus.annul_i) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == CW'(W)) begin
          state_nxt_s = ST_END;
        end else begin
          state_nxt_s = ST_ON;
        end
      end
      ST_END: begin
        if (!bus.start_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_END;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath helpers: operand magnitudes, restoring trial, sign-corrected result
  always_comb begin
    abs1_s    = (bus.signed_div_i && bus.opdata1_i[W-1]) ? (~bus.opdata1_i + {{(W-1){1'b0}}, 1'b1})
                                                         : bus.opdata1_i;
    abs2_s    = (bus.signed_div_i && bus.opdata2_i[W-1]) ? (~bus.opdata2_i + {{(W-1){1'b0}}, 1'b1})
                                                         : bus.opdata2_i;
    trial_s   = {rem_r[W-1:0], quo_r[W-1]} - {1'b0, div_r};
    quo_fix_s = (sdiv_r && (s1_r ^ s2_r)) ? (~quo_r + {{(W-1){1'b0}}, 1'b1}) : quo_r;
    rem_fix_s = (sdiv_r && s1_r) ? (~rem_r[W-1:0] + {{(W-1){1'b0}}, 1'b1}) : rem_r[W-1:0];
  end

  // Output and datapath next values
  always_comb begin
    cnt_nxt_s    = cnt_r;
    rem_nxt_s    = rem_r;
    quo_nxt_s    = quo_r;
    div_nxt_s    = div_r;
    sdiv_nxt_s   = sdiv_r;
    s1_nxt_s     = s1_r;
    s2_nxt_s     = s2_r;
    result_nxt_s = {(2*W){1'b0}};
    ready_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = {CW{1'b0}};
        if (bus.start_i && !bus.annul_i) begin
          sdiv_nxt_s = bus.signed_div_i;
          s1_nxt_s   = bus.opdata1_i[W-1];
          s2_nxt_s   = bus.opdata2_i[W-1];
          quo_nxt_s  = abs1_s;
          div_nxt_s  = abs2_s;
          rem_nxt_s  = {(W+1){1'b0}};
        end else begin
          rem_nxt_s  = rem_r;
        end
      end
      ST_BYZERO: begin
        if (bus.annul_i) begin
          ready_nxt_s = 1'b0;
        end else begin
          ready_nxt_s = 1'b1;
        end
      end
      ST_ON: begin
        if (bus.annul_i) begin
          cnt_nxt_s = {CW{1'b0}};
        end else if (cnt_r == CW'(W)) begin
          result_nxt_s = {rem_fix_s, quo_fix_s};
          ready_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
          // Restore by keeping the shifted remainder when the trial goes negative
          if (!trial_s[W]) begin
            rem_nxt_s = trial_s;
            quo_nxt_s = {quo_r[W-2:0], 1'b1};
          end else begin
            rem_nxt_s = {rem_r[W-1:0], quo_r[W-1]};
            quo_nxt_s = {quo_r[W-2:0], 1'b0};
          end
        end
      end
      ST_END: begin
        if (bus.start_i) begin
          result_nxt_s = result_r;
          ready_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s    = {CW{1'b0}};
        end
      end
      default: begin
        cnt_nxt_s = {CW{1'b0}};
      end
    endcase
  end

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: directed divides push expected result and ready edge,
// a negedge monitor pops and compares on each rising ready_o.
module tb_div_iter;

  typedef struct {
    logic [63:0] res;
    int          at;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic prev_ready = 1'b0;
  exp_t sbq[$];

  div_iter_if #(.DATA_WD(32)) bus ();

  div_iter #(.DATA_WD(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every rising ready_o must match the oldest expected entry
  always @(negedge clk) begin
    if (bus.ready_o && !prev_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got result %h expected no ready", bus.result_o);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check({e.name, "_result"}, bus.result_o, e.res);
        check({e.name, "_latency"}, 64'(cyc), 64'(e.at));
      end
    end
    prev_ready = bus.ready_o;
  end

  // Issue one divide from a negedge; lat = edges from start edge to ready visible
  task automatic do_div(input string nm, input logic sd, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int lat,
                        input bit corrupt, input bit hold);
    exp_t e;
    bus.signed_div_i = sd;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    e.res  = exp;
    e.at   = cyc + 1 + lat;
    e.name = nm;
    sbq.push_back(e);
    @(negedge clk);
    if (corrupt) begin
      bus.opdata1_i    = ~a;
      bus.opdata2_i    = 32'd3;
      bus.signed_div_i = ~sd;
    end
    for (int i = 0; i < 40 && !bus.ready_o; i++) @(negedge clk);
    if (!bus.ready_o) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got ready 0 expected ready 1", nm);
      sbq.delete();
    end
    if (hold) begin
      @(negedge clk);
      check({nm, "_hold_result"}, bus.result_o, exp);
      check({nm, "_hold_ready"}, {63'd0, bus.ready_o}, 64'd1);
    end
    bus.start_i = 1'b0;
    @(negedge clk);
    check({nm, "_drop_ready"}, {63'd0, bus.ready_o}, 64'd0);
    check({nm, "_drop_result"}, bus.result_o, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready", {63'd0, bus.ready_o}, 64'd0);
    check("reset_result", bus.result_o, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_div("u100_7",  1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33, 1'b0, 1'b1);
    do_div("s_m7_2",  1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 33, 1'b0, 1'b0);
    do_div("s_7_m2",  1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33, 1'b0, 1'b0);
    do_div("byzero",  1'b0, 32'd5,          32'd0,          64'h00000000_00000000, 1,  1'b0, 1'b1);
    do_div("u_max_1", 1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33, 1'b0, 1'b0);
    do_div("s_ovf",   1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33, 1'b0, 1'b0);
    do_div("u_ovf",   1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 33, 1'b0, 1'b0);

    // Annul partway through a 1000 / 3 divide
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    repeat (10) @(negedge clk);
    bus.annul_i = 1'b1;
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    check("annul_ready", {63'd0, bus.ready_o}, 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ready_o) seen++;
    end
    check("annul_no_ready", 64'(seen), 64'd0);
    do_div("u1000_3", 1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D, 33, 1'b0, 1'b0);

    // Asynchronous reset between edges in the middle of a divide
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd3;
    bus.start_i   = 1'b1;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_ready", {63'd0, bus.ready_o}, 64'd0);
    check("rst_mid_result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_div("fresh_s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33, 1'b1, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
